// File: rtl/fse_fir_filter.sv
// fse_fir_filter
//   Fractionally-spaced (T/2) FIR equalizer feeding the LMS adaptation stage.
//   Filters the T/2 sample stream with the live LMS coefficient vector,
//   decimates by 2, truncates/saturates to the output format and slices a
//   hard decision.
//
// Ports
//   clkA      in   sole clock, rising edge
//   reset     in   synchronous active-high reset
//   i_enable  in   input sample strobe
//   x         in   signed T/2 sample, Q(NBx-NBFx).NBFx
//   coeff     in   packed taps, tap k at [NBw*(k+1)-1 -: NBw]
//   y         out  signed equalized symbol, Q(NBy-NBFy).NBFy
//   d         out  slicer decision, 1 when y >= 0
//   o_valid   out  one-cycle pulse, y/d/o_sat updated this cycle
//   o_sat     out  y was clipped when produced
//
// Pipeline: C0 accept sample -> C1 products -> C2 sum -> C3 quantize/output.

module fse_fir_filter #(
    parameter int NBx  = 8,
    parameter int NBFx = 5,
    parameter int Nw   = 9,
    parameter int NBw  = 7,
    parameter int NBFw = 5,
    parameter int NBy  = 8,
    parameter int NBFy = 5
) (
    input  logic                clkA,
    input  logic                reset,
    input  logic                i_enable,
    input  logic [NBx-1:0]      x,
    input  logic [Nw*NBw-1:0]   coeff,
    output logic [NBy-1:0]      y,
    output logic                d,
    output logic                o_valid,
    output logic                o_sat
);

    localparam int NBP = NBx + NBw;              // full-precision product
    localparam int NBA = NBP + $clog2(Nw);       // accumulator, cannot overflow
    localparam int SH  = NBFx + NBFw - NBFy;     // LSBs dropped by truncation
    localparam int NBT = NBA - SH;               // truncated width before clipping

    logic signed [NBx-1:0] x_r [Nw];
    logic signed [NBw-1:0] w   [Nw];
    logic signed [NBP-1:0] p   [Nw];
    logic signed [NBA-1:0] acc;
    logic signed [NBA-1:0] sum;
    logic signed [NBT-1:0] trunc;
    logic [NBy-1:0]        y_q;
    logic                  pos_ovf;
    logic                  neg_ovf;
    logic                  phase;
    logic                  v0, v1, v2;
    logic                  unused_lsbs;

    for (genvar k = 0; k < Nw; k++) begin : g_taps
        assign w[k] = coeff[NBw*(k+1)-1 -: NBw];
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < Nw; k++) begin
            sum = sum + NBA'(p[k]);
        end
    end

    // Truncation is a plain arithmetic shift, i.e. floor toward -inf.
    assign trunc       = acc[NBA-1:SH];
    assign unused_lsbs = ^acc[SH-1:0];

    // Out of range when the bits above the output sign bit disagree with it.
    assign pos_ovf = ~trunc[NBT-1] &  (|trunc[NBT-2:NBy-1]);
    assign neg_ovf =  trunc[NBT-1] & ~(&trunc[NBT-2:NBy-1]);

    always_comb begin
        y_q = trunc[NBy-1:0];
        if (pos_ovf) begin
            y_q = {1'b0, {(NBy-1){1'b1}}};
        end else if (neg_ovf) begin
            y_q = {1'b1, {(NBy-1){1'b0}}};
        end
    end

    always_ff @(posedge clkA) begin
        if (reset) begin
            for (int k = 0; k < Nw; k++) begin
                x_r[k] <= '0;
                p[k]   <= '0;
            end
            phase   <= 1'b0;
            v0      <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            acc     <= '0;
            y       <= '0;
            d       <= 1'b0;
            o_sat   <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            // C0: delay line and phase only advance on accepted samples
            if (i_enable) begin
                x_r[0] <= x;
                for (int k = 1; k < Nw; k++) begin
                    x_r[k] <= x_r[k-1];
                end
                phase <= ~phase;
            end
            v0 <= i_enable & phase;

            // C1: coeff is used straight from the port, no local copy
            for (int k = 0; k < Nw; k++) begin
                p[k] <= NBP'(x_r[k]) * NBP'(w[k]);
            end
            v1 <= v0;

            // C2
            acc <= sum;
            v2  <= v1;

            // C3: outputs hold between valid pulses
            o_valid <= v2;
            if (v2) begin
                y     <= y_q;
                d     <= ~y_q[NBy-1];
                o_sat <= pos_ovf | neg_ovf;
            end
        end
    end

endmodule

// File: tb/tb_fse_fir_filter.sv
// tb_fse_fir_filter
//   Directed-vector bench for fse_fir_filter with hand-computed expectations:
//   impulse, truncation, saturation and its boundaries, decimation/latency,
//   mid-stream reset and live coefficient change.

module tb_fse_fir_filter;

    logic        clkA = 1'b0;
    logic        reset;
    logic        i_enable;
    logic [7:0]  x;
    logic [62:0] coeff;
    logic [7:0]  y;
    logic        d;
    logic        o_valid;
    logic        o_sat;

    int total = 0;
    int bad   = 0;

    fse_fir_filter dut (
        .clkA     (clkA),
        .reset    (reset),
        .i_enable (i_enable),
        .x        (x),
        .coeff    (coeff),
        .y        (y),
        .d        (d),
        .o_valid  (o_valid),
        .o_sat    (o_sat)
    );

    always #5 clkA = ~clkA;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive inputs, take one rising edge, settle 1 time unit past it.
    task automatic cyc(input logic en, input logic [7:0] xv);
        i_enable = en;
        x        = xv;
        @(posedge clkA);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) cyc(1'b1, 8'h55);
        reset = 1'b0;
    endtask

    function automatic logic [62:0] one_tap(input logic [6:0] wv);
        logic [62:0] r;
        r = '0;
        r[4*7 +: 7] = wv;
        return r;
    endfunction

    // Stream a constant with i_enable every cycle; the final outputs then
    // come from a symbol whose nine taps all hold that constant.
    task automatic run_const(input logic [7:0] xv);
        for (int i = 0; i < 14; i++) cyc(1'b1, xv);
    endtask

    // Zero, impulse 1.0, zeros. Symbol samples are the even ones; the impulse
    // reaches tap4 at sample 6, whose output appears after edge 9.
    task automatic impulse_run(input string tag);
        logic ev;
        coeff = one_tap(7'h20);
        for (int c = 1; c <= 16; c++) begin
            cyc(1'b1, (c == 2) ? 8'h20 : 8'h00);
            ev = (c >= 5) && (c % 2 == 1);
            chk({tag, "_valid"}, int'(o_valid), int'(ev));
            if (ev) begin
                chk({tag, "_y"}, int'(y), (c == 9) ? 'h20 : 'h00);
                chk({tag, "_d"}, int'(d), 1);
                chk({tag, "_sat"}, int'(o_sat), 0);
            end else if (c < 5) begin
                chk({tag, "_y_idle"}, int'(y), 0);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        i_enable = 1'b0;
        x        = '0;
        coeff    = '0;

        // Reset state
        do_reset(2);
        chk("rst_y", int'(y), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_sat", int'(o_sat), 0);

        // T1 + T4a: impulse, every-cycle enable, first valid 3 after sample 2
        impulse_run("imp");

        // T2: 0.5 * -0.96875 = -0.484375 -> floor to -0.5
        do_reset(1);
        coeff = one_tap(7'h10);
        run_const(8'hE1);
        chk("trunc_y", int'(y), 'hF0);
        chk("trunc_d", int'(d), 0);
        chk("trunc_sat", int'(o_sat), 0);

        // T3: all taps ~1.97, full-scale inputs clip both ways
        coeff = {9{7'h3F}};
        run_const(8'h7F);
        chk("satp_y", int'(y), 'h7F);
        chk("satp_d", int'(d), 1);
        chk("satp_sat", int'(o_sat), 1);
        run_const(8'h80);
        chk("satn_y", int'(y), 'h80);
        chk("satn_d", int'(d), 0);
        chk("satn_sat", int'(o_sat), 1);

        // Boundaries: 65*63 = 4095 -> 127 exactly fits; -128*32 -> -128 fits
        coeff = one_tap(7'h3F);
        run_const(8'h41);
        chk("edgep_y", int'(y), 'h7F);
        chk("edgep_sat", int'(o_sat), 0);
        coeff = one_tap(7'h20);
        run_const(8'h80);
        chk("edgen_y", int'(y), 'h80);
        chk("edgen_sat", int'(o_sat), 0);
        chk("edgen_d", int'(d), 0);

        // T4b: enable every 3rd cycle -> symbols at c=4,10,... valid at 7,13,...
        do_reset(1);
        coeff = one_tap(7'h20);
        for (int c = 1; c <= 30; c++) begin
            cyc((c % 3) == 1, 8'h10);
            chk("dec3_valid", int'(o_valid), int'((c >= 7) && ((c - 7) % 6 == 0)));
        end

        // T5: reset mid-stream with results in flight, then clean impulse
        do_reset(1);
        coeff = one_tap(7'h20);
        for (int c = 1; c <= 12; c++) cyc(1'b1, 8'h20);
        chk("pre_rst_y", int'(y), 'h20);
        do_reset(1);
        chk("mid_rst_y", int'(y), 0);
        chk("mid_rst_valid", int'(o_valid), 0);
        impulse_run("rimp");

        // T6: tap4 = 0.5 only during C1 of the symbol accepted at c=12
        do_reset(1);
        for (int c = 1; c <= 18; c++) begin
            coeff = one_tap((c == 13) ? 7'h10 : 7'h20);
            cyc(1'b1, 8'h20);
            if (c == 13 || c == 15 || c == 17) begin
                chk("live_valid", int'(o_valid), 1);
                chk("live_y", int'(y), (c == 15) ? 'h10 : 'h20);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
